// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] RV_NOP           = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

    // One buffered fetch: the word and the PC it was fetched from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Force an address onto a 4-byte instruction boundary
    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; flush wins over push/pop.
module fetch_buf
    import fetch_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  fetch_entry_t           i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output fetch_entry_t           o_head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_en;
    logic          w_pop_en;

    // Pop only real entries; refuse a push into a full buffer unless a pop frees a slot
    assign w_pop_en  = i_pop && (r_count != '0);
    assign w_push_en = i_push && ((r_count != CW'(DEPTH)) || w_pop_en);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push_en) - CW'(w_pop_en);
        end
    end

    // Payload storage; contents are qualified by r_count so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push_en && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited requests, buffers responses for decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_o_req_valid,
    input  logic            imem_i_req_ready,
    output logic [XLEN-1:0] imem_o_addr,
    input  logic            imem_i_resp_valid,
    input  logic [ILEN-1:0] imem_i_instr,
    input  logic            execute_i_redirect,
    input  logic [XLEN-1:0] execute_i_redirect_pc,
    input  logic            decode_i_stall,
    output logic            fetch_o_valid,
    output logic [ILEN-1:0] fetch_o_instr,
    output logic [XLEN-1:0] fetch_o_pc
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned UW = CW + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_buf_count;
    logic [UW-1:0]   w_used;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic [XLEN-1:0] w_target;
    logic            w_credit;
    logic            w_fire;
    logic            w_dropping;
    logic            w_push;
    logic            w_pop;

    // Credits: outstanding requests plus buffered words never exceed the buffer size
    assign w_used   = UW'(r_inflight) + UW'(w_buf_count);
    assign w_credit = w_used < UW'(BUF_DEPTH);

    // Request side; held low through reset and in any redirect cycle
    assign imem_o_req_valid = rst && !execute_i_redirect && w_credit;
    assign imem_o_addr      = r_fetch_pc;
    assign w_fire           = imem_o_req_valid && imem_i_req_ready;

    // Response side: stale words are swallowed while drop_cnt is non-zero
    assign w_dropping  = r_drop_cnt != '0;
    assign w_push      = imem_i_resp_valid && !w_dropping && !execute_i_redirect;
    assign w_push_data = '{pc: r_resp_pc, instr: imem_i_instr};
    assign w_target    = align4(execute_i_redirect_pc);

    // Decode side: head entry presented straight from the buffer registers
    assign fetch_o_valid = w_buf_count != '0;
    assign fetch_o_instr = fetch_o_valid ? w_head.instr : RV_NOP;
    assign fetch_o_pc    = fetch_o_valid ? w_head.pc    : '0;
    assign w_pop         = fetch_o_valid && !decode_i_stall && !execute_i_redirect;

    // PC, in-flight and drop tracking; a redirect marks every outstanding request stale
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_fire) - CW'(imem_i_resp_valid);
            if (execute_i_redirect) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_drop_cnt <= r_inflight - CW'(imem_i_resp_valid);
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + XLEN'(4);
                end
                if (imem_i_resp_valid && w_dropping) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
            end
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (execute_i_redirect),
        .o_count     (w_buf_count),
        .o_head      (w_head)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table, directed corner sequences and random traffic vs a queue model.
module tb_fetch_stage;

    localparam int unsigned DEPTH = 2;
    localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_o_req_valid;
    logic        imem_i_req_ready = 1'b0;
    logic [63:0] imem_o_addr;
    logic        imem_i_resp_valid = 1'b0;
    logic [31:0] imem_i_instr = 32'h0;
    logic        execute_i_redirect = 1'b0;
    logic [63:0] execute_i_redirect_pc = 64'h0;
    logic        decode_i_stall = 1'b0;
    logic        fetch_o_valid;
    logic [31:0] fetch_o_instr;
    logic [63:0] fetch_o_pc;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .imem_o_req_valid      (imem_o_req_valid),
        .imem_i_req_ready      (imem_i_req_ready),
        .imem_o_addr           (imem_o_addr),
        .imem_i_resp_valid     (imem_i_resp_valid),
        .imem_i_instr          (imem_i_instr),
        .execute_i_redirect    (execute_i_redirect),
        .execute_i_redirect_pc (execute_i_redirect_pc),
        .decode_i_stall        (decode_i_stall),
        .fetch_o_valid         (fetch_o_valid),
        .fetch_o_instr         (fetch_o_instr),
        .fetch_o_pc            (fetch_o_pc)
    );

    // Memory requests in flight and decode-visible buffer, as transaction queues
    typedef struct {
        logic [63:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        rdy;
        logic        stl;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
    } vec_t;

    mreq_t       mem_q[$];
    ent_t        buf_q[$];
    logic [63:0] m_fetch_pc = RPC;
    int          cyc      = 0;
    int          last_due = 0;
    int          mem_lat  = 1;
    bit          resp_now;
    bit          dut_fire;
    logic [63:0] dut_addr;
    int          n_checks = 0;
    int          n_err    = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        chk(name, 64'(act), 64'(exp));
    endfunction

    // Hold reset, check reset outputs, clear model and memory, release on a falling edge
    task automatic do_reset();
        @(negedge clk);
        rst                   = 1'b0;
        imem_i_req_ready      = 1'b0;
        imem_i_resp_valid     = 1'b0;
        imem_i_instr          = 32'h0;
        execute_i_redirect    = 1'b0;
        execute_i_redirect_pc = 64'h0;
        decode_i_stall        = 1'b0;
        mem_q.delete();
        buf_q.delete();
        m_fetch_pc = RPC;
        last_due   = cyc;
        @(negedge clk);
        chk1("rst_valid", fetch_o_valid, 1'b0);
        chk("rst_instr", 64'(fetch_o_instr), 64'h13);
        chk("rst_pc", fetch_o_pc, 64'h0);
        chk1("rst_req", imem_o_req_valid, 1'b0);
        chk("rst_addr", imem_o_addr, RPC);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: drive inputs and memory response, compare against model, advance model
    task automatic step(input logic rdy, input logic stl, input logic rdr, input logic [63:0] rpc);
        bit    exp_req;
        bit    fire;
        mreq_t m;
        @(posedge clk);
        #1;
        cyc++;
        imem_i_req_ready      = rdy;
        decode_i_stall        = stl;
        execute_i_redirect    = rdr;
        execute_i_redirect_pc = rpc;
        resp_now = 1'b0;
        if (mem_q.size() > 0) begin
            if (mem_q[0].due <= cyc) resp_now = 1'b1;
        end
        imem_i_resp_valid = resp_now;
        if (resp_now) imem_i_instr = mem_q[0].addr[31:0];
        else          imem_i_instr = $urandom;
        @(negedge clk);
        dut_fire = imem_o_req_valid && imem_i_req_ready;
        dut_addr = imem_o_addr;

        exp_req = !rdr && ((mem_q.size() + buf_q.size()) < int'(DEPTH));
        chk1("req_valid", imem_o_req_valid, exp_req);
        chk("addr", imem_o_addr, m_fetch_pc);
        chk1("valid", fetch_o_valid, buf_q.size() > 0);
        if (buf_q.size() > 0) begin
            chk("pc", fetch_o_pc, buf_q[0].pc);
            chk("instr", 64'(fetch_o_instr), 64'(buf_q[0].instr));
        end else begin
            chk("pc", fetch_o_pc, 64'h0);
            chk("instr", 64'(fetch_o_instr), 64'h13);
        end

        fire = exp_req && rdy;
        if (rdr) begin
            if (resp_now) m = mem_q.pop_front();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            buf_q.delete();
            m_fetch_pc = {rpc[63:2], 2'b00};
        end else begin
            if (buf_q.size() > 0 && !stl) void'(buf_q.pop_front());
            if (resp_now) begin
                m = mem_q.pop_front();
                if (!m.stale) buf_q.push_back('{m.addr, m.addr[31:0]});
            end
            if (fire) begin
                m.addr  = m_fetch_pc;
                m.due   = (cyc + mem_lat > last_due + 1) ? cyc + mem_lat : last_due + 1;
                m.stale = 1'b0;
                last_due = m.due;
                mem_q.push_back(m);
                m_fetch_pc = m_fetch_pc + 64'd4;
            end
        end
    endtask

    vec_t vt[10];
    bit   got_fire;
    bit   got_valid;
    logic [63:0] tgt;

    initial begin
        // Cycle-by-cycle expectations after reset, 1-cycle memory, stall in cycles 5-6
        vt[0] = '{1'b1, 1'b0, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
        vt[1] = '{1'b1, 1'b0, 1'b1, 64'h8000_0004, 1'b0, 64'h0};
        vt[2] = '{1'b1, 1'b0, 1'b0, 64'h8000_0008, 1'b1, 64'h8000_0000};
        vt[3] = '{1'b1, 1'b0, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004};
        vt[4] = '{1'b1, 1'b0, 1'b1, 64'h8000_000C, 1'b0, 64'h0};
        vt[5] = '{1'b1, 1'b1, 1'b0, 64'h8000_0010, 1'b1, 64'h8000_0008};
        vt[6] = '{1'b1, 1'b1, 1'b0, 64'h8000_0010, 1'b1, 64'h8000_0008};
        vt[7] = '{1'b1, 1'b0, 1'b0, 64'h8000_0010, 1'b1, 64'h8000_0008};
        vt[8] = '{1'b1, 1'b0, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_000C};
        vt[9] = '{1'b1, 1'b0, 1'b1, 64'h8000_0014, 1'b0, 64'h0};

        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 10; i++) begin
            step(vt[i].rdy, vt[i].stl, 1'b0, 64'h0);
            chk1("vec_req", imem_o_req_valid, vt[i].e_req);
            chk("vec_addr", imem_o_addr, vt[i].e_addr);
            chk1("vec_valid", fetch_o_valid, vt[i].e_valid);
            chk("vec_pc", fetch_o_pc, vt[i].e_pc);
        end

        // Long decode stall: buffer fills, requests stop, nothing lost after release
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 64'h0);
        chk1("stall_full_req", imem_o_req_valid, 1'b0);
        chk1("stall_full_valid", fetch_o_valid, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 64'h0);

        // Redirect with two slow requests outstanding: both stale, refetch at aligned target
        do_reset();
        mem_lat = 3;
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_1002);
        got_fire  = 1'b0;
        got_valid = 1'b0;
        for (int k = 0; k < 20 && !got_valid; k++) begin
            step(1'b1, 1'b0, 1'b0, 64'h0);
            if (!got_fire && dut_fire) begin
                got_fire = 1'b1;
                chk("redir_first_addr", dut_addr, 64'h0000_0000_8000_1000);
            end
            if (fetch_o_valid) begin
                got_valid = 1'b1;
                chk("redir_first_pc", fetch_o_pc, 64'h0000_0000_8000_1000);
            end
        end
        if (!got_valid) chk1("redir_timeout", got_valid, 1'b1);

        // Redirect coinciding with a response and a decode pop
        do_reset();
        mem_lat = 1;
        tgt = 64'h0000_0000_9000_0104;
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b1, tgt);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        chk1("rsp_redir_empty", fetch_o_valid, 1'b0);
        chk1("rsp_redir_req", imem_o_req_valid, 1'b1);
        chk("rsp_redir_addr", imem_o_addr, tgt);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        chk1("rsp_redir_valid", fetch_o_valid, 1'b1);
        chk("rsp_redir_pc", fetch_o_pc, tgt);
        chk("rsp_redir_instr", 64'(fetch_o_instr), 64'h9000_0104);

        // Memory not ready: request held with a stable address
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 64'h0);
            chk1("nrdy_req", imem_o_req_valid, 1'b1);
            chk("nrdy_addr", imem_o_addr, RPC);
        end
        step(1'b1, 1'b0, 1'b0, 64'h0);
        chk("rdy_addr0", imem_o_addr, RPC);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        chk("rdy_addr1", imem_o_addr, RPC + 64'd4);

        // Asynchronous reset mid-stream with a full buffer
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 64'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk1("arst_valid", fetch_o_valid, 1'b0);
        chk("arst_instr", 64'(fetch_o_instr), 64'h13);
        chk("arst_pc", fetch_o_pc, 64'h0);
        chk1("arst_req", imem_o_req_valid, 1'b0);
        chk("arst_addr", imem_o_addr, RPC);
        do_reset();
        step(1'b1, 1'b0, 1'b0, 64'h0);
        chk("arst_restart_addr", dut_addr, RPC);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 64'h0);

        // Random traffic: variable latency, ready, stalls and redirects incl. near address wrap
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        r_rdy;
            logic        r_stl;
            logic        r_rdr;
            logic [63:0] r_pc;
            mem_lat = int'($urandom_range(1, 4));
            r_rdy   = ($urandom % 4) != 0;
            r_stl   = ($urandom % 10) < 3;
            r_rdr   = ($urandom % 25) == 0;
            if (($urandom % 4) == 0) r_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom % 16);
            else                     r_pc = {32'($urandom), 32'($urandom)};
            step(r_rdy, r_stl, r_rdr, r_pc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch front end for the 5-stage RV64IM pipeline. It sits directly upstream of the D-stage register that feeds the decoder. It owns the PC, issues word requests to instruction memory, and absorbs response latency in a small instruction buffer. It presents {valid, instr, pc} to decode, honours decode stalls, and discards stale fetches on branch or jump redirects from execute.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC fetched first after reset
BUF_DEPTH, 2, instruction buffer entries and maximum credits (power of 2, ≥2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
imem_o_req_valid  output  1  fetch request valid
imem_i_req_ready  input  1  memory accepts request this cycle
imem_o_addr  output  64  request address, 4-byte aligned
imem_i_resp_valid  input  1  response valid; in order; no backpressure
imem_i_instr  input  32  response instruction word
execute_i_redirect  input  1  taken branch or jump; flush and refetch
execute_i_redirect_pc  input  64  redirect target
decode_i_stall  input  1  decode cannot accept this cycle
fetch_o_valid  output  1  fetch_o_instr/fetch_o_pc are valid
fetch_o_instr  output  32  instruction; NOP 32'h0000_0013 when not valid
fetch_o_pc  output  64  PC of fetch_o_instr; 0 when not valid

Behaviour:
- Reset (rst=0, asynchronous) drives the following values:
  - fetch PC = RESET_PC; expected-response PC = RESET_PC.
  - inflight = 0, drop_cnt = 0, buffer empty.
  - imem_o_req_valid = 0, imem_o_addr = RESET_PC.
  - fetch_o_valid = 0, fetch_o_instr = NOP, fetch_o_pc = 0.
- Request side:
  - imem_o_req_valid = !execute_i_redirect && (inflight + buf_count < BUF_DEPTH).
  - imem_o_addr = fetch PC.
  - On fire (valid && ready): fetch PC += 4, inflight += 1.
  - A request may be withdrawn only in a redirect cycle.
- Response side:
  - Every imem_i_resp_valid decrements inflight.
  - If drop_cnt > 0: the word is discarded and drop_cnt -= 1.
  - Otherwise: push {imem_i_instr, expected-response PC} and add 4 to the expected-response PC.
  - Credit rule guarantees a push never overflows the buffer.
- Output side:
  - The head entry is driven combinationally from buffer registers.
  - Pop when fetch_o_valid && !decode_i_stall.
  - Push and pop in the same cycle are both performed.
- Latency: response in cycle r is visible on fetch_o_* in r+1. Minimum request-to-decode latency is 2 cycles with 1-cycle memory.
- Redirect (cycle t):
  - Buffer flushed; fetch_o_valid = 0 from t+1.
  - Fetch PC and expected-response PC = {redirect_pc[63:2], 2'b00}.
  - drop_cnt = inflight - (imem_i_resp_valid ? 1 : 0); a response in cycle t is itself discarded.
  - Request for the target is issued at t+1 at the earliest.
- Simultaneous events:
  - Redirect beats pop, push and stall.
  - Redirect while drop_cnt > 0 recomputes drop_cnt from inflight; all outstanding requests are stale.
  - Stall with a full buffer and no credits means no requests.
- Counter widths: inflight, buf_count and drop_cnt are $clog2(BUF_DEPTH)+1 bits. Pointers wrap modulo BUF_DEPTH.
- Fetch PC wraps modulo 2^64 without a flag.
- Reset mid-operation abandons all state. Late responses after reset are ignored because inflight = 0 only when the memory is also reset; this is a system requirement.

Decomposition:
- Shared package: RV_NOP = 32'h0000_0013, default RESET_PC, XLEN = 64.
- One sub-module: fetch_buf, a synchronous FIFO of {pc[63:0], instr[31:0]}.
  - Ports: push, pop, flush, count, head.
  - flush has priority over push and pop.

Test Plan:
1. Reset release, memory ready, 1-cycle response returning addr[31:0] → requests at 0x80000000, 0x80000004, …; fetch_o_pc matches fetch_o_instr; first fetch_o_valid 2 cycles after reset release.
2. decode_i_stall held 6 cycles, memory always ready → at most BUF_DEPTH in flight plus buffered; no entry lost or duplicated after release; output held stable while stalled.
3. 3-cycle response latency with 2 outstanding, then redirect to 0x80001002 → both late responses dropped; next request addr 0x80001000; first valid pc 0x80001000.
4. Redirect in the same cycle as imem_i_resp_valid and a decode pop → response dropped, buffer empty next cycle, drop_cnt = inflight - 1.
5. imem_i_req_ready = 0 for 4 cycles → req_valid held with stable addr; fetch PC advances only on fire.
6. Assert rst mid-stream with a full buffer → outputs take reset values immediately (asynchronously); fetch restarts at RESET_PC.
